binary_gcd: RTL and testbench
=============================

Name: binary_gcd

Overview:
- Upstream stage of the factor finder in the Pollard p-1 datapath.
- Takes the reduced exponentiation result `a` and the modulus `n`, and computes g = gcd(a, n) with Stein's binary algorithm: shifts and subtracts only, no divider.
- Raises `nontrivial` when 1 < g < n. The factor finder then divides n by g to get the cofactor.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHIFT_W, 6, width of the common-power-of-two counter; must satisfy 2^SHIFT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- a  input  WIDTH  first operand, 0 <= a < n.
- n  input  WIDTH  modulus.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse when `gcd` is valid.
- gcd  output  WIDTH  result; held from `done` until the next accepted start.
- nontrivial  output  1  (gcd > 1) && (gcd < latched n); valid with `gcd`.

Behaviour:
- Reset (also applies mid-operation): state goes to IDLE; busy=0, done=0, gcd=0, nontrivial=0; internal u, v, k cleared.
- State machine, one state action per clock:
  - IDLE: on start=1, load u<=a', v<=n, n_q<=n, k<=0, go to CHECK. a' is defined under Optional Feature.
  - CHECK:
    - u==0: go to FINISH with result v.
    - else v==0: go to FINISH with result u.
    - else go to STRIP.
  - STRIP:
    - u[0]==0 and v[0]==0: shift u and v right by 1, k<=k+1, stay.
    - else go to REDUCE.
  - REDUCE, evaluated in priority order:
    - u==0: go to FINISH with result v.
    - u even: u<=u>>1.
    - v even: v<=v>>1.
    - u>=v: u<=u-v.
    - else: v<=v-u.
  - FINISH: gcd<=result<<k; nontrivial computed against n_q; go to DONE.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency: start to done is at most 4*WIDTH+6 cycles.
- Arithmetic rules:
  - Subtraction is unsigned and never underflows (guarded by the u>=v compare).
  - The left shift by k cannot overflow, since g <= max(a', n).
- start while busy: ignored; no effect on the running operation.
- start on the same cycle as reset: reset wins.
- Both operands zero: gcd=0, nontrivial=0.
- n changing while busy: no effect; n_q is used.

Optional Feature:
- Macro: GCD_MINUS_ONE_EN.
- With the macro defined, a' = a-1, which forms Pollard's gcd(x-1, n). For a==0, a' = n-1, i.e. x-1 reduced mod n.
- Without the macro, a' = a.
- Port list and timing are identical in both builds.

Decomposition:
- Shared package pollard_pkg holds:
  - the WIDTH default constant, shared with the factor finder and divider;
  - the gcd_state_t enum (IDLE, CHECK, STRIP, REDUCE, FINISH, DONE).
- No sub-module. The datapath is one comparator, one subtractor and shifters, all kept in this module.

Test Plan:
- a=12, n=18, start pulse -> one done pulse; gcd=6, nontrivial=1; done within 4*WIDTH+6 cycles; busy high throughout.
- a=17, n=35 -> gcd=1, nontrivial=0. Then a=0, n=35 -> gcd=35, nontrivial=0.
- a=0xFFFFFFFE, n=0xFFFFFFFF -> gcd=1, nontrivial=0, done inside the latency bound. Then a=0x80000000, n=0x40000000 -> gcd=0x40000000, nontrivial=0.
- Assert reset 5 cycles after starting a=12, n=18 -> next cycle busy=0, gcd=0, and no done pulse. A following start with a=14, n=21 -> gcd=7, nontrivial=1.
- start re-pulsed with a=5, n=10 while busy on a=12, n=18 -> a single done with gcd=6; the second request is dropped.
- With GCD_MINUS_ONE_EN: a=8, n=35 -> gcd=7, nontrivial=1. a=0, n=35 -> gcd(34, 35)=1, nontrivial=0.

Source files
------------

// File: rtl/pollard_pkg.sv
// Constants and types shared by the Pollard p-1 datapath blocks (gcd, factor finder, divider).
package pollard_pkg;

  localparam int POLLARD_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STRIP,
    REDUCE,
    FINISH,
    DONE
  } gcd_state_t;

endpackage

// File: rtl/binary_gcd.sv
// Stein binary gcd(a', n) with a nontrivial-factor flag; a' = a, or a-1 when GCD_MINUS_ONE_EN is defined.
// Latency: start to done is at most 4*WIDTH+6 cycles.
// Backpressure: none; start is ignored while busy.
module binary_gcd
  import pollard_pkg::*;
#(
  parameter int WIDTH   = POLLARD_WIDTH,
  parameter int SHIFT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd,
  output logic             nontrivial
);

  gcd_state_t         state_q, state_d;
  logic [WIDTH-1:0]   u, v, res, n_q;
  logic [SHIFT_W-1:0] k;
  logic [WIDTH-1:0]   a_eff;
  logic [WIDTH-1:0]   g_shift;

`ifdef GCD_MINUS_ONE_EN
  // x-1 reduced mod n: a==0 stands for x==n, so the operand becomes n-1.
  assign a_eff = (a == '0) ? (n - WIDTH'(1)) : (a - WIDTH'(1));
`else
  assign a_eff = a;
`endif

  assign g_shift = res << k;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CHECK;
      CHECK:   state_d = ((u == '0) || (v == '0)) ? FINISH : STRIP;
      STRIP:   if (u[0] || v[0]) state_d = REDUCE;
      REDUCE:  if (u == '0) state_d = FINISH;
      FINISH:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      u          <= '0;
      v          <= '0;
      k          <= '0;
      res        <= '0;
      n_q        <= '0;
      gcd        <= '0;
      nontrivial <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            u   <= a_eff;
            v   <= n;
            n_q <= n;
            k   <= '0;
          end
        end
        CHECK: begin
          if (u == '0)      res <= v;
          else if (v == '0) res <= u;
        end
        STRIP: begin
          if (!u[0] && !v[0]) begin
            u <= u >> 1;
            v <= v >> 1;
            k <= k + SHIFT_W'(1);
          end
        end
        REDUCE: begin
          // Both odd before a subtract, so the difference is even and the next step halves it.
          if (u == '0)    res <= v;
          else if (!u[0]) u   <= u >> 1;
          else if (!v[0]) v   <= v >> 1;
          else if (u >= v) u  <= u - v;
          else             v  <= v - u;
        end
        FINISH: begin
          gcd        <= g_shift;
          nontrivial <= (g_shift > WIDTH'(1)) && (g_shift < n_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_gcd.sv
// Self-checking bench for binary_gcd against a Euclid-based reference gcd.
module tb_binary_gcd;

  localparam int W       = 32;
  localparam int LAT_MAX = 4 * W + 6;
  localparam int LAT_CAP = 400;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, n;
  logic         busy, done, nontrivial;
  logic [W-1:0] gcd;

  int n_cmp = 0;
  int n_err = 0;

  binary_gcd dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .n(n),
    .busy(busy), .done(done), .gcd(gcd), .nontrivial(nontrivial)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_aprime(input logic [W-1:0] x, input logic [W-1:0] m);
`ifdef GCD_MINUS_ONE_EN
    return (x == 0) ? m - 1 : x - 1;
`else
    return x;
`endif
  endfunction

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x0, input logic [W-1:0] y0);
    logic [W-1:0] x, y, t;
    x = x0;
    y = y0;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic ref_nt(input logic [W-1:0] g, input logic [W-1:0] m);
    return (g > 1) && (g < m);
  endfunction

  // Drives one request, scrambles the inputs while busy, and reports what was observed.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] ni,
                        output logic [W-1:0] g, output logic nt, output int lat,
                        output bit busy_ok, output bit done_one);
    busy_ok = 1'b1;
    @(negedge clk);
    a = ai; n = ni; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < LAT_CAP) begin
      if (!busy) busy_ok = 1'b0;
      a = $urandom; n = $urandom;
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    g  = gcd;
    nt = nontrivial;
    @(negedge clk);
    done_one = !done && !busy && (gcd === g);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; a = 12; n = 18;
    repeat (3) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (gcd !== '0) begin n_err++; $display("FAIL reset_gcd got=%h want=0", gcd); end
    n_cmp++; if (nontrivial !== 1'b0) begin n_err++; $display("FAIL reset_nt got=%b want=0", nontrivial); end
  endtask

  task automatic test_directed(input logic [W-1:0] ai, input logic [W-1:0] ni,
                               input logic [W-1:0] g_exp, input logic nt_exp);
    logic [W-1:0] g; logic nt; int lat; bit bok, d1;
    run_op(ai, ni, g, nt, lat, bok, d1);
    n_cmp++; if (g !== g_exp) begin n_err++; $display("FAIL dir_gcd a=%h n=%h got=%h want=%h", ai, ni, g, g_exp); end
    n_cmp++; if (nt !== nt_exp) begin n_err++; $display("FAIL dir_nt a=%h n=%h got=%b want=%b", ai, ni, nt, nt_exp); end
    n_cmp++; if (lat > LAT_MAX) begin n_err++; $display("FAIL dir_latency a=%h n=%h got=%0d want<=%0d", ai, ni, lat, LAT_MAX); end
    n_cmp++; if (!bok) begin n_err++; $display("FAIL dir_busy a=%h n=%h got=dropped want=held", ai, ni); end
    n_cmp++; if (!d1) begin n_err++; $display("FAIL dir_done_pulse a=%h n=%h got=not_single want=single", ai, ni); end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] g; logic nt; int lat; bit bok, d1; int dones;
    @(negedge clk);
    a = 12; n = 18; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got=%b want=0", busy); end
    n_cmp++; if (gcd !== '0) begin n_err++; $display("FAIL midreset_gcd got=%h want=0", gcd); end
    dones = 0;
    for (int i = 0; i < 150; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL midreset_no_done got=%0d want=0", dones); end
    run_op(14, 21, g, nt, lat, bok, d1);
    n_cmp++; if (g !== ref_gcd(ref_aprime(14, 21), 21)) begin n_err++; $display("FAIL midreset_next_gcd got=%h want=%h", g, ref_gcd(ref_aprime(14, 21), 21)); end
    n_cmp++; if (nt !== ref_nt(ref_gcd(ref_aprime(14, 21), 21), 21)) begin n_err++; $display("FAIL midreset_next_nt got=%b", nt); end
  endtask

  task automatic test_start_while_busy;
    int dones;
    logic [W-1:0] g_seen, g_exp;
    g_exp = ref_gcd(ref_aprime(12, 18), 18);
    g_seen = '0;
    @(negedge clk);
    a = 12; n = 18; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 5; n = 10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 2 * LAT_MAX; i++) begin
      if (done) begin dones++; g_seen = gcd; end
      @(negedge clk);
    end
    n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL busy_start_dones got=%0d want=1", dones); end
    n_cmp++; if (g_seen !== g_exp) begin n_err++; $display("FAIL busy_start_gcd got=%h want=%h", g_seen, g_exp); end
  endtask

  task automatic test_random;
    logic [W-1:0] ai, ni, g, ge; logic nt; int lat; bit bok, d1;
    logic [63:0] f;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        ni = $urandom;
        if (ni == 0) ni = 1;
        ai = $urandom % ni;
      end else begin
        f  = 64'($urandom_range(2, 5000));
        ni = W'(f * 64'($urandom_range(1, 600000)));
        ai = W'((f * 64'($urandom)) % 64'(ni));
      end
      run_op(ai, ni, g, nt, lat, bok, d1);
      ge = ref_gcd(ref_aprime(ai, ni), ni);
      n_cmp++; if (g !== ge || nt !== ref_nt(ge, ni) || lat > LAT_MAX || !bok || !d1) begin
        n_err++;
        $display("FAIL rand a=%h n=%h got gcd=%h nt=%b lat=%0d busy=%b pulse=%b want gcd=%h nt=%b", ai, ni, g, nt, lat, bok, d1, ge, ref_nt(ge, ni));
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; a = '0; n = '0;
    test_reset();
`ifdef GCD_MINUS_ONE_EN
    test_directed(32'd8, 32'd35, 32'd7, 1'b1);
    test_directed(32'd0, 32'd35, 32'd1, 1'b0);
`else
    test_directed(32'd12, 32'd18, 32'd6, 1'b1);
    test_directed(32'd17, 32'd35, 32'd1, 1'b0);
    test_directed(32'd0, 32'd35, 32'd35, 1'b0);
    test_directed(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 1'b0);
    test_directed(32'd0, 32'd0, 32'd0, 1'b0);
    test_directed(32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
`endif
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
